// File: rtl/adder_bist_pkg.sv
// Shared types and sizing for the adder BIST controller.
// Optional stop-on-first-error build: ADDER_BIST_STOP_ON_ERR_EN.
package adder_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CHECK,
        DONE
    } state_e;

    localparam int WIDTH_DEF = 6;
    localparam int VEC_BITS  = 2 * WIDTH_DEF;
    localparam int VEC_LAST  = (1 << VEC_BITS) - 1;
    localparam int ERR_W     = VEC_BITS + 1;

endpackage

// File: rtl/adder_bist_cmp.sv
// Golden-sum checker: flags when the adder result differs from x + y.
// Pure combinational so other checkers can reuse it.
module adder_bist_cmp #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] s,
    input  logic             cout,
    output logic             mismatch
);

    logic [WIDTH:0] golden;

    assign golden   = {1'b0, x} + {1'b0, y};
    assign mismatch = (golden != {cout, s});

endmodule

// File: rtl/adder_bist_ctrl.sv
// Exhaustive self-test sequencer for a WIDTH-bit adder with on-chip compare.
// Define ADDER_BIST_STOP_ON_ERR_EN to halt on the first failing vector.
module adder_bist_ctrl
    import adder_bist_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   x_out,
    output logic [WIDTH-1:0]   y_out,
    input  logic [WIDTH-1:0]   s_in,
    input  logic               cout_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               err_valid,
    output logic [2*WIDTH-1:0] first_err_idx
);

    localparam int VB = 2 * WIDTH;
    localparam int EW = VB + 1;
    localparam logic [VB-1:0] IDX_ONE = 1;
    localparam logic [EW-1:0] ERR_ONE = 1;

    state_e          state_q, state_d;
    logic [VB-1:0]   idx_q, idx_d;
    logic [3:0]      wait_q, wait_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [EW-1:0]   err_q, err_d;
    logic            errv_q, errv_d;
    logic [VB-1:0]   first_q, first_d;

    logic            mismatch;
    logic [EW-1:0]   err_nx;
    logic            stop;

    adder_bist_cmp #(.WIDTH(WIDTH)) u_cmp (
        .x        (x_q),
        .y        (y_q),
        .s        (s_in),
        .cout     (cout_in),
        .mismatch (mismatch)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        x_d     = x_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        errv_d  = errv_q;
        first_d = first_q;
        err_nx  = err_q;
        stop    = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    err_d   = '0;
                    errv_d  = 1'b0;
                    first_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                x_d     = idx_q[VB-1:WIDTH];
                y_d     = idx_q[WIDTH-1:0];
                wait_d  = 4'(SETTLE);
                state_d = (SETTLE > 0) ? WAIT : CHECK;
            end
            WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_q <= 4'd1) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_nx = (err_q == '1) ? err_q : err_q + ERR_ONE;
                    if (!errv_q) begin
                        errv_d  = 1'b1;
                        first_d = idx_q;
                    end
                end
                err_d = err_nx;
                stop  = (idx_q == '1);
`ifdef ADDER_BIST_STOP_ON_ERR_EN
                stop  = stop || mismatch;
`endif
                if (stop) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_nx == '0);
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            errv_q  <= 1'b0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            errv_q  <= errv_d;
            first_q <= first_d;
        end
    end

    assign x_out         = x_q;
    assign y_out         = y_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign err_valid     = errv_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Scoreboard bench for adder_bist_ctrl driving a fault-injectable adder model.
// Expected run results are hand-derived per fault mode.
module tb_adder_bist_ctrl;

    localparam int W   = 6;
    localparam int RUN = 4096 * 3;

    typedef struct {
        int err;
        int first;
        int errv;
        int pass;
        int x;
        int y;
        int len;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   x_out;
    logic [W-1:0]   y_out;
    logic [W-1:0]   s_in;
    logic           cout_in;
    logic           busy;
    logic           done;
    logic           pass;
    logic [2*W:0]   err_count;
    logic           err_valid;
    logic [2*W-1:0] first_err_idx;

    int   fault;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    adder_bist_ctrl #(.WIDTH(W), .SETTLE(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .x_out         (x_out),
        .y_out         (y_out),
        .s_in          (s_in),
        .cout_in       (cout_in),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .err_valid     (err_valid),
        .first_err_idx (first_err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural adder: 0 good, 1 S[0] stuck-at-0, 2 cout forced 0
    always_comb begin
        {cout_in, s_in} = {1'b0, x_out} + {1'b0, y_out};
        if (fault == 1) s_in[0] = 1'b0;
        if (fault == 2) cout_in = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: on every rising done, pop and compare the run summary
    int  busy_cyc;
    logic done_prev;
    initial begin
        exp_t e;
        busy_cyc  = 0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cyc  = 0;
                done_prev = 1'b0;
            end else begin
                if (busy) busy_cyc++;
                if (done && !done_prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("run_len", busy_cyc, e.len);
                        check("err_count", int'(err_count), e.err);
                        check("first_err_idx", int'(first_err_idx), e.first);
                        check("err_valid", int'(err_valid), e.errv);
                        check("pass", int'(pass), e.pass);
                        check("busy_at_done", int'(busy), 0);
                        check("x_out", int'(x_out), e.x);
                        check("y_out", int'(y_out), e.y);
                    end
                    busy_cyc = 0;
                end
                done_prev = done;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < RUN + 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) check({name, "_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    task automatic push(input int err, input int first, input int x,
                        input int y, input int len);
        exp_t e;
        e.err   = err;
        e.first = first;
        e.errv  = (err != 0) ? 1 : 0;
        e.pass  = (err == 0) ? 1 : 0;
        e.x     = x;
        e.y     = y;
        e.len   = len;
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x"}, int'(x_out), 0);
        check({tag, "_y"}, int'(y_out), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_err"}, int'(err_count), 0);
        check({tag, "_errv"}, int'(err_valid), 0);
        check({tag, "_first"}, int'(first_err_idx), 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        fault    = 0;
        start    = 1'b0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Good adder; stray start mid-run must be ignored
        push(0, 0, 63, 63, RUN);
        pulse_start();
        check("busy_after_start", int'(busy), 1);
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("good");

        // S[0] stuck-at-0, restarted straight from DONE
        fault = 1;
`ifdef ADDER_BIST_STOP_ON_ERR_EN
        push(1, 1, 0, 1, 6);
`else
        push(2048, 1, 63, 63, RUN);
`endif
        pulse_start();
        check("done_cleared_on_restart", int'(done), 0);
        check("err_cleared_on_restart", int'(err_count), 0);
        wait_done("s0_stuck");

        // cout forced low: first failure at x=1, y=63
        fault = 2;
`ifdef ADDER_BIST_STOP_ON_ERR_EN
        push(1, 12'h07F, 1, 63, 128 * 3);
`else
        push(2016, 12'h07F, 63, 63, RUN);
`endif
        pulse_start();
        wait_done("cout_low");

        // Async abort mid-run, then a clean full pass
        fault = 1;
        pulse_start();
        repeat (498) @(negedge clk);
        check("busy_before_abort", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst   = 1'b0;
        fault = 0;
        push(0, 0, 63, 63, RUN);
        pulse_start();
        wait_done("after_abort");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
